// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types: configuration, command/response encodings, limiter state
// and the command/response classification helpers.
package pzcorebus_pkg;
    localparam int PZCOREBUS_ID_WIDTH      = 4;
    localparam int PZCOREBUS_ADDRESS_WIDTH = 32;
    localparam int PZCOREBUS_LENGTH_WIDTH  = 4;
    localparam int PZCOREBUS_DATA_WIDTH    = 32;

    typedef enum logic {
        PZCOREBUS_MEMORY_PROFILE = 1'b0,
        PZCOREBUS_CSR_PROFILE    = 1'b1
    } pzcorebus_profile;

    typedef struct packed {
        pzcorebus_profile profile;
    } pzcorebus_config;

    // Bit 2 set marks every command class that expects a response.
    typedef enum logic [2:0] {
        PZCOREBUS_NULL_COMMAND       = 3'b000,
        PZCOREBUS_MESSAGE            = 3'b001,
        PZCOREBUS_WRITE              = 3'b010,
        PZCOREBUS_READ               = 3'b100,
        PZCOREBUS_MESSAGE_NON_POSTED = 3'b101,
        PZCOREBUS_WRITE_NON_POSTED   = 3'b110,
        PZCOREBUS_ATOMIC             = 3'b111
    } pzcorebus_command_type;

    typedef enum logic {
        PZCOREBUS_RESPONSE           = 1'b0,
        PZCOREBUS_RESPONSE_WITH_DATA = 1'b1
    } pzcorebus_response_type;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } pzcorebus_limiter_state;

    function automatic logic is_non_posted_command(pzcorebus_command_type mcmd);
        return mcmd[2];
    endfunction

    // sresp_last[0] closes a burst unit, sresp_last[1] closes the whole response.
    function automatic logic is_final_response(logic [1:0] sresp_last);
        return sresp_last[1];
    endfunction
endpackage

// File: rtl/pzcorebus_if.sv
// pzcorebus request/response interface with master and slave views.
interface pzcorebus_if;
    import pzcorebus_pkg::*;

    // Every channel is valid/accept: a beat transfers on a clock edge where both
    // are high; once valid is raised the payload is held stable until accepted.
    logic                                 mcmd_valid;
    logic                                 scmd_accept;
    pzcorebus_command_type                mcmd;
    logic [PZCOREBUS_ID_WIDTH-1:0]        mid;
    logic [PZCOREBUS_ADDRESS_WIDTH-1:0]   maddr;
    logic [PZCOREBUS_LENGTH_WIDTH-1:0]    mlength;
    logic                                 mdata_valid;
    logic                                 sdata_accept;
    logic [PZCOREBUS_DATA_WIDTH-1:0]      mdata;
    logic                                 mdata_last;
    logic                                 sresp_valid;
    logic                                 mresp_accept;
    pzcorebus_response_type               sresp;
    logic [PZCOREBUS_ID_WIDTH-1:0]        sid;
    logic                                 serror;
    logic [PZCOREBUS_DATA_WIDTH-1:0]      sdata;
    logic [1:0]                           sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength,
        output mdata_valid, mdata, mdata_last, mresp_accept,
        input  scmd_accept, sdata_accept,
        input  sresp_valid, sresp, sid, serror, sdata, sresp_last
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength,
        input  mdata_valid, mdata, mdata_last, mresp_accept,
        output scmd_accept, sdata_accept,
        output sresp_valid, sresp, sid, serror, sdata, sresp_last
    );
endinterface

// File: rtl/pzcorebus_outstanding_counter.sv
// Up/down outstanding-command counter with full/empty flags and a sticky
// underflow error flag.
module pzcorebus_outstanding_counter #(
    parameter int  MAX_OUTSTANDING = 8,
    localparam int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    input  logic                   dec,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   error
);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_next;
    logic                   error_next;

    // A simultaneous inc and dec cancel; a lone dec at zero is a stray response.
    always_comb begin
        count_next = count;
        error_next = error;
        if (inc && !dec) begin
            if (count != MAX_COUNT) begin
                count_next = count + ONE;
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                error_next = 1'b1;
            end else begin
                count_next = count - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            error <= 1'b0;
        end else begin
            count <= count_next;
            error <= error_next;
        end
    end

    assign full  = (count == MAX_COUNT);
    assign empty = (count == '0);
endmodule

// File: rtl/pzcorebus_outstanding_limiter.sv
// Caps in-flight non-posted pzcorebus commands and offers a drain handshake.
// PZCOREBUS_OUTSTANDING_LIMITER_STALL_COUNTER_EN adds the limit-stall cycle counter.
module pzcorebus_outstanding_limiter
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG      = '0,
    parameter int              MAX_OUTSTANDING = 8,
    localparam int             COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_drain_req,
    output logic                   o_drain_ack,
    output logic [COUNT_WIDTH-1:0] o_outstanding,
    output logic                   o_error,
    output logic [31:0]            o_stall_count,
    pzcorebus_if.slave             slave_if,
    pzcorebus_if.master            master_if
);
    pzcorebus_limiter_state state;
    pzcorebus_limiter_state state_next;
    logic                   full;
    logic                   empty;
    logic                   block;
    logic                   final_beat;
    logic                   inc;
    logic                   dec;

    // Gate uses only registered state, so a slot freed this cycle opens next cycle.
    assign block = full || (state != RUN);

    assign master_if.mcmd_valid  = slave_if.mcmd_valid && !block;
    assign slave_if.scmd_accept  = master_if.scmd_accept && !block;
    assign master_if.mcmd        = slave_if.mcmd;
    assign master_if.mid         = slave_if.mid;
    assign master_if.maddr       = slave_if.maddr;
    assign master_if.mlength     = slave_if.mlength;

    assign master_if.mdata_valid = slave_if.mdata_valid;
    assign master_if.mdata       = slave_if.mdata;
    assign master_if.mdata_last  = slave_if.mdata_last;
    assign slave_if.sdata_accept = master_if.sdata_accept;

    assign slave_if.sresp_valid  = master_if.sresp_valid;
    assign slave_if.sresp        = master_if.sresp;
    assign slave_if.sid          = master_if.sid;
    assign slave_if.serror       = master_if.serror;
    assign slave_if.sdata        = master_if.sdata;
    assign slave_if.sresp_last   = master_if.sresp_last;
    assign master_if.mresp_accept = slave_if.mresp_accept;

    // CSR-profile responses are always single beat.
    assign final_beat = (BUS_CONFIG.profile == PZCOREBUS_CSR_PROFILE) ||
                        is_final_response(master_if.sresp_last);
    assign inc = master_if.mcmd_valid && master_if.scmd_accept &&
                 is_non_posted_command(master_if.mcmd);
    assign dec = master_if.sresp_valid && slave_if.mresp_accept && final_beat;

    pzcorebus_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_counter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (inc),
        .dec   (dec),
        .count (o_outstanding),
        .full  (full),
        .empty (empty),
        .error (o_error)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (i_drain_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!i_drain_req) state_next = RUN;
                else if (empty) state_next = DRAINED;
            end
            DRAINED: begin
                if (!i_drain_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    assign o_drain_ack = (state == DRAINED);

`ifdef PZCOREBUS_OUTSTANDING_LIMITER_STALL_COUNTER_EN
    logic [31:0] stall_count;

    // Only limit stalls are counted, saturating at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_count <= '0;
        end else if (slave_if.mcmd_valid && full && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign o_stall_count = stall_count;
`else
    assign o_stall_count = '0;
`endif
endmodule

// File: doc/pzcorebus_outstanding_limiter.md
Name: pzcorebus_outstanding_limiter

Overview:
- Single-clock request-side stage placed directly upstream of the clock-crossing FIFO on the slave-clock side.
- Caps the number of in-flight non-posted commands at MAX_OUTSTANDING, so the response path downstream can never hold more than that many response messages.
- Supports a drain handshake so software or a power controller can quiesce the bus before a clock or reset change.
- Write data and responses pass through combinationally; only the command channel is gated.

Parameters:
- BUS_CONFIG, '0: pzcorebus_config of both interfaces; must be identical on each side.
- MAX_OUTSTANDING, 8: maximum accepted-but-unanswered non-posted commands; legal range 1..1023.
- COUNT_WIDTH, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter; localparam, derived, not overridable.

Ports:
- i_clk  input  1  bus clock; single clock domain.
- i_rst_n  input  1  asynchronous active-low reset.
- i_drain_req  input  1  level request to quiesce the command channel.
- o_drain_ack  output  1  high while drained: no new commands are issued and the outstanding count is 0.
- o_outstanding  output  COUNT_WIDTH  current outstanding count.
- o_error  output  1  sticky; set on a final response arriving while the count is 0.
- o_stall_count  output  32  cycles a valid command was blocked by the limit; optional feature.
- slave_if  pzcorebus_if.slave  -  upstream request/response interface.
- master_if  pzcorebus_if.master  -  downstream interface, feeding the async FIFO.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - count=0, state=RUN, o_error=0, o_stall_count=0, o_drain_ack=0.
- Pass-through:
  - mdata_*, sdata_accept, sresp_*, mresp_accept are wired straight through with zero latency.
  - mcmd payload is wired straight through.
- Command gating: block = (count==MAX_OUTSTANDING) || (state!=RUN).
  - master_if.mcmd_valid = slave_if.mcmd_valid && !block.
  - slave_if.scmd_accept = master_if.scmd_accept && !block.
  - The gate never depends on same-cycle response retirement; a slot freed in cycle N is usable in cycle N+1.
- Increment (inc): a command handshake (master-side valid && accept) whose command is non-posted per the package helper. Posted writes and posted messages never count.
- Decrement (dec): a response handshake (sresp_valid && mresp_accept) on a beat the package helper marks as final for its command. Intermediate beats of multi-beat responses do not decrement.
- Count update:
  - inc only: +1.
  - dec only: -1.
  - inc and dec together: unchanged.
  - dec at count 0: count stays 0 and o_error sets.
  - o_error clears only on reset.
- State machine, registered:
  - RUN -> DRAIN when i_drain_req=1.
  - DRAIN -> DRAINED when count==0. If the count is already 0 on entry, DRAINED is reached the next cycle.
  - DRAIN -> RUN if i_drain_req drops before drained.
  - DRAINED -> RUN when i_drain_req=0.
  - o_drain_ack = (state==DRAINED), registered.
- Mid-command drain: a command already presented but unaccepted is held; valid is masked downstream. Upstream must keep it stable per pzcorebus rules; this stage does not drop it.
- Write data of a masked write command may still flow. Data precedence is legal on pzcorebus.
- Reset mid-operation clears all state immediately; in-flight responses later cause o_error.

Optional Feature:
- Macro: PZCOREBUS_OUTSTANDING_LIMITER_STALL_COUNTER_EN.
- Defined:
  - o_stall_count increments by 1 each cycle that slave_if.mcmd_valid=1 and count==MAX_OUTSTANDING.
  - It saturates at 32'hFFFF_FFFF.
  - Drain blocking is not counted.
- Undefined: o_stall_count is tied to 0 and no counter flops exist.

Decomposition:
- pzcorebus_pkg gains is_non_posted_command(mcmd) and is_final_response(sresp_last) helper functions.
- pzcorebus_pkg gains a pzcorebus_limiter_state enum {RUN, DRAIN, DRAINED}.
- One sub-module is natural: pzcorebus_outstanding_counter, holding the up/down saturating counter, full flag and error flag, parameterized by MAX_OUTSTANDING.

Test Plan:
- MAX_OUTSTANDING=4; issue 6 back-to-back reads, no responses -> 4 accepted, o_outstanding=4, scmd_accept=0. With the feature enabled, o_stall_count counts every cycle read 5 waits.
- Count 4; one final response accepted -> o_outstanding=3 the next cycle, and read 5 is accepted in that cycle, not earlier.
- 10 posted writes at count 0 -> all pass, o_outstanding stays 0.
- Read accepted and final response in the same cycle at count 2 -> count stays 2. A 4-beat response with only the last beat final decrements once.
- Count 3, assert i_drain_req -> commands masked. After 3 final responses, o_drain_ack=1 one cycle after count reaches 0. Deassert the request -> RUN and commands resume.
- Final response at count 0 -> o_error=1, count stays 0; o_error is held until i_rst_n=0.
